// File: rtl/apb2axi_pkg.sv
// Shared AXI-side constants for the APB-to-AXI bridge.
package apb2axi_pkg;
  localparam int unsigned AXI_ID_W = 4;
endpackage

// File: rtl/apb2axi_wr_tag_ctrl.sv
// Write-tag controller: allocates AWIDs, tracks FREE->ALLOC->ISSUED->DONE per tag,
// accepts B responses and returns completions round-robin.
module apb2axi_wr_tag_ctrl
  import apb2axi_pkg::*;
#(
  parameter  int unsigned TAG_NUM = 4,
  localparam int unsigned TAG_W   = $clog2(TAG_NUM)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                alloc_req,
  output logic                alloc_gnt,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                issue_vld,
  input  logic [TAG_W-1:0]    issue_tag,
  input  logic                bvalid,
  output logic                bready,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  output logic                cpl_vld,
  output logic [TAG_W-1:0]    cpl_tag,
  output logic [1:0]          cpl_resp,
  input  logic                cpl_rdy,
  output logic [TAG_NUM-1:0]  tag_busy,
  output logic                all_idle,
  output logic                err_pulse
);

  typedef enum logic [1:0] {
    TAG_FREE   = 2'b00,
    TAG_ALLOC  = 2'b01,
    TAG_ISSUED = 2'b10,
    TAG_DONE   = 2'b11
  } tag_state_e;

  tag_state_e       state_q [TAG_NUM];
  tag_state_e       state_d [TAG_NUM];
  logic [1:0]       resp_q  [TAG_NUM];
  logic [1:0]       resp_d  [TAG_NUM];
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cpl_vld_q, cpl_vld_d;
  logic [TAG_W-1:0] cpl_tag_q, cpl_tag_d;
  logic [1:0]       cpl_resp_q, cpl_resp_d;
  logic             err_q, err_d;
  logic             bready_q;

  logic             free_found;
  logic [TAG_W-1:0] free_idx;
  logic             pick_found;
  logic [TAG_W-1:0] pick_idx;
  logic [TAG_W-1:0] cand_idx;
  logic             b_hs;
  logic             cpl_hs;
  logic             bid_hi_ok;
  logic [TAG_W-1:0] b_tag;

  assign b_hs      = bvalid & bready_q;
  assign cpl_hs    = cpl_vld_q & cpl_rdy;
  assign b_tag     = bid[TAG_W-1:0];
  assign bid_hi_ok = ((bid >> TAG_W) == '0);

  // Lowest-index FREE tag; a tag freed this cycle is still DONE here, so no same-cycle reuse.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(TAG_NUM) - 1; i >= 0; i--) begin
      if (state_q[i] == TAG_FREE) begin
        free_found = 1'b1;
        free_idx   = TAG_W'(i);
      end
    end
  end

  assign alloc_gnt = alloc_req & free_found;
  assign alloc_tag = free_idx;

  // Round-robin search from rr_ptr over DONE tags, skipping the one being handed off now.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = int'(TAG_NUM) - 1; k >= 0; k--) begin
      cand_idx = rr_ptr_q + TAG_W'(k);
      if (state_q[cand_idx] == TAG_DONE && !(cpl_hs && cand_idx == cpl_tag_q)) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_d     = resp_q;
    rr_ptr_d   = rr_ptr_q;
    cpl_vld_d  = cpl_vld_q;
    cpl_tag_d  = cpl_tag_q;
    cpl_resp_d = cpl_resp_q;
    err_d      = 1'b0;

    if (alloc_gnt) begin
      state_d[free_idx] = TAG_ALLOC;
    end

    if (issue_vld) begin
      if (state_q[issue_tag] == TAG_ALLOC) begin
        state_d[issue_tag] = TAG_ISSUED;
      end else begin
        err_d = 1'b1;
      end
    end

    // Judged on the current state, so a B racing its own AW issue counts as unexpected.
    if (b_hs) begin
      if (bid_hi_ok && state_q[b_tag] == TAG_ISSUED) begin
        state_d[b_tag] = TAG_DONE;
        resp_d[b_tag]  = bresp;
      end else begin
        err_d = 1'b1;
      end
    end

    if (cpl_hs) begin
      state_d[cpl_tag_q] = TAG_FREE;
    end

    if (!cpl_vld_q || cpl_rdy) begin
      if (pick_found) begin
        cpl_vld_d  = 1'b1;
        cpl_tag_d  = pick_idx;
        cpl_resp_d = resp_q[pick_idx];
        rr_ptr_d   = pick_idx + TAG_W'(1);
      end else begin
        cpl_vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(TAG_NUM); i++) begin
        state_q[i] <= TAG_FREE;
        resp_q[i]  <= 2'b00;
      end
      rr_ptr_q   <= '0;
      cpl_vld_q  <= 1'b0;
      cpl_tag_q  <= '0;
      cpl_resp_q <= 2'b00;
      err_q      <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_q     <= resp_d;
      rr_ptr_q   <= rr_ptr_d;
      cpl_vld_q  <= cpl_vld_d;
      cpl_tag_q  <= cpl_tag_d;
      cpl_resp_q <= cpl_resp_d;
      err_q      <= err_d;
      bready_q   <= 1'b1;
    end
  end

  always_comb begin
    tag_busy = '0;
    for (int i = 0; i < int'(TAG_NUM); i++) begin
      tag_busy[i] = (state_q[i] != TAG_FREE);
    end
  end

  assign all_idle  = ~(|tag_busy) & ~cpl_vld_q;
  assign bready    = bready_q;
  assign cpl_vld   = cpl_vld_q;
  assign cpl_tag   = cpl_tag_q;
  assign cpl_resp  = cpl_resp_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_apb2axi_wr_tag_ctrl.sv
// Directed bench for apb2axi_wr_tag_ctrl; completions are checked by a scoreboard monitor.
module tb_apb2axi_wr_tag_ctrl;
  import apb2axi_pkg::*;

  localparam int unsigned TAG_NUM = 4;
  localparam int unsigned TAG_W   = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0]       resp;
  } exp_t;

  logic                aclk;
  logic                aresetn;
  logic                alloc_req;
  logic                alloc_gnt;
  logic [TAG_W-1:0]    alloc_tag;
  logic                issue_vld;
  logic [TAG_W-1:0]    issue_tag;
  logic                bvalid;
  logic                bready;
  logic [AXI_ID_W-1:0] bid;
  logic [1:0]          bresp;
  logic                cpl_vld;
  logic [TAG_W-1:0]    cpl_tag;
  logic [1:0]          cpl_resp;
  logic                cpl_rdy;
  logic [TAG_NUM-1:0]  tag_busy;
  logic                all_idle;
  logic                err_pulse;

  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];
  exp_t mon_e;

  apb2axi_wr_tag_ctrl #(.TAG_NUM(TAG_NUM)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_tag (alloc_tag),
    .issue_vld (issue_vld),
    .issue_tag (issue_tag),
    .bvalid    (bvalid),
    .bready    (bready),
    .bid       (bid),
    .bresp     (bresp),
    .cpl_vld   (cpl_vld),
    .cpl_tag   (cpl_tag),
    .cpl_resp  (cpl_resp),
    .cpl_rdy   (cpl_rdy),
    .tag_busy  (tag_busy),
    .all_idle  (all_idle),
    .err_pulse (err_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Completion monitor: every accepted completion must match the next expected entry.
  always @(negedge aclk) begin
    if (aresetn && cpl_vld && cpl_rdy) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL cpl_unexpected: got tag=%0d resp=%0d, required no completion", cpl_tag, cpl_resp);
      end else begin
        mon_e = sb_q.pop_front();
        if (cpl_tag !== mon_e.tag || cpl_resp !== mon_e.resp) begin
          n_err++;
          $display("FAIL cpl_order: got tag=%0d resp=%0d, required tag=%0d resp=%0d",
                   cpl_tag, cpl_resp, mon_e.tag, mon_e.resp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) tick();
    check(nm, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    aresetn   = 1'b0;
    alloc_req = 1'b0;
    issue_vld = 1'b0;
    issue_tag = '0;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = 2'b00;
    cpl_rdy   = 1'b0;

    // Reset values
    repeat (2) @(posedge aclk);
    #1;
    check("rst_cpl_vld",  32'(cpl_vld),   32'd0);
    check("rst_tag_busy", 32'(tag_busy),  32'd0);
    check("rst_all_idle", 32'(all_idle),  32'd1);
    check("rst_bready",   32'(bready),    32'd0);
    check("rst_err",      32'(err_pulse), 32'd0);
    aresetn = 1'b1;
    settle();
    check("rel_bready0", 32'(bready), 32'd0);
    tick();
    check("rel_bready1", 32'(bready), 32'd1);

    // Five back-to-back allocations on four tags
    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("alloc_gnt", 32'(alloc_gnt), 32'd1);
      check("alloc_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    settle();
    check("alloc_full_gnt", 32'(alloc_gnt), 32'd0);
    check("alloc_full_busy", 32'(tag_busy), 32'hF);
    tick();
    check("alloc_full_gnt2", 32'(alloc_gnt), 32'd0);
    alloc_req = 1'b0;

    // Issue all, B out of order; completions follow DONE order with stored resps
    for (int i = 0; i < 4; i++) begin
      issue_vld = 1'b1;
      issue_tag = TAG_W'(i);
      tick();
    end
    issue_vld = 1'b0;
    settle();
    check("issue_no_err", 32'(err_pulse), 32'd0);
    sb_q.push_back(exp_t'({2'd2, 2'd0}));
    sb_q.push_back(exp_t'({2'd0, 2'd2}));
    sb_q.push_back(exp_t'({2'd3, 2'd0}));
    sb_q.push_back(exp_t'({2'd1, 2'd3}));
    cpl_rdy = 1'b1;
    bvalid  = 1'b1;
    bid = AXI_ID_W'(2); bresp = 2'd0; tick();
    bid = AXI_ID_W'(0); bresp = 2'd2; tick();
    bid = AXI_ID_W'(3); bresp = 2'd0; tick();
    bid = AXI_ID_W'(1); bresp = 2'd3; tick();
    bvalid = 1'b0;
    drain("t3_drain");
    tick();
    check("t3_busy", 32'(tag_busy), 32'd0);
    check("t3_idle", 32'(all_idle), 32'd1);
    check("t3_err",  32'(err_pulse), 32'd0);
    cpl_rdy = 1'b0;

    // Protocol errors
    alloc_req = 1'b1;
    settle(); check("t4_alloc0", 32'(alloc_tag), 32'd0);
    tick();   check("t4_alloc1", 32'(alloc_tag), 32'd1);
    tick();
    alloc_req = 1'b0;
    bvalid = 1'b1; bid = AXI_ID_W'(1); bresp = 2'd0;
    tick();
    bvalid = 1'b0;
    check("t4_b_alloc_err",  32'(err_pulse), 32'd1);
    check("t4_b_alloc_busy", 32'(tag_busy),  32'h3);
    tick();
    check("t4_err_clear", 32'(err_pulse), 32'd0);
    issue_vld = 1'b1; issue_tag = TAG_W'(3);
    tick();
    issue_vld = 1'b0;
    check("t4_issue_free_err",  32'(err_pulse), 32'd1);
    check("t4_issue_free_busy", 32'(tag_busy),  32'h3);
    tick();
    issue_vld = 1'b1; issue_tag = TAG_W'(1); tick();
    check("t4_issue1_ok", 32'(err_pulse), 32'd0);
    issue_tag = TAG_W'(0); tick();
    issue_vld = 1'b0;
    check("t4_issue0_ok", 32'(err_pulse), 32'd0);
    bvalid = 1'b1; bid = AXI_ID_W'(1) << TAG_W; bresp = 2'd1;
    tick();
    bvalid = 1'b0;
    check("t4_bid_hi_err", 32'(err_pulse), 32'd1);
    tick();
    alloc_req = 1'b1;
    settle(); check("t4_alloc2", 32'(alloc_tag), 32'd2);
    tick();
    alloc_req = 1'b0;
    issue_vld = 1'b1; issue_tag = TAG_W'(2);
    bvalid = 1'b1; bid = AXI_ID_W'(2); bresp = 2'd1;
    tick();
    issue_vld = 1'b0; bvalid = 1'b0;
    check("t4_race_err", 32'(err_pulse), 32'd1);
    tick();
    check("t4_race_clear", 32'(err_pulse), 32'd0);
    check("t4_race_busy",  32'(tag_busy),  32'h7);
    check("t4_no_cpl",     32'(cpl_vld),   32'd0);

    // Backpressure: tag0 held while tag2 waits
    bvalid = 1'b1; bid = AXI_ID_W'(0); bresp = 2'd1; tick();
    bid = AXI_ID_W'(2); bresp = 2'd3; tick();
    bvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("t5_hold_vld", 32'(cpl_vld),  32'd1);
      check("t5_hold_tag", 32'(cpl_tag),  32'd0);
      check("t5_hold_rsp", 32'(cpl_resp), 32'd1);
      tick();
    end
    sb_q.push_back(exp_t'({2'd0, 2'd1}));
    sb_q.push_back(exp_t'({2'd2, 2'd3}));
    cpl_rdy = 1'b1;
    drain("t5_drain");
    tick();
    cpl_rdy = 1'b0;
    check("t5_busy", 32'(tag_busy), 32'h2);

    // Freed tag is not grantable in the cycle of its handoff
    alloc_req = 1'b1;
    settle(); check("t6_alloc0", 32'(alloc_tag), 32'd0);
    tick();   check("t6_alloc2", 32'(alloc_tag), 32'd2);
    tick();   check("t6_alloc3", 32'(alloc_tag), 32'd3);
    tick();   check("t6_full",   32'(alloc_gnt), 32'd0);
    alloc_req = 1'b0;
    issue_vld = 1'b1; issue_tag = TAG_W'(0); tick();
    issue_vld = 1'b0;
    bvalid = 1'b1; bid = AXI_ID_W'(0); bresp = 2'd2; tick();
    bvalid = 1'b0;
    tick();
    check("t6_cpl_vld", 32'(cpl_vld), 32'd1);
    check("t6_cpl_tag", 32'(cpl_tag), 32'd0);
    sb_q.push_back(exp_t'({2'd0, 2'd2}));
    cpl_rdy   = 1'b1;
    alloc_req = 1'b1;
    settle();
    check("t6_same_cycle_gnt", 32'(alloc_gnt), 32'd0);
    tick();
    cpl_rdy = 1'b0;
    check("t6_next_gnt",  32'(alloc_gnt), 32'd1);
    check("t6_next_tag",  32'(alloc_tag), 32'd0);
    check("t6_cpl_clear", 32'(cpl_vld),   32'd0);
    tick();
    alloc_req = 1'b0;
    check("t6_busy", 32'(tag_busy), 32'hF);

    // Reset with a completion pending discards it
    bvalid = 1'b1; bid = AXI_ID_W'(1); bresp = 2'd2; tick();
    bvalid = 1'b0;
    tick();
    check("t1_pend_vld", 32'(cpl_vld), 32'd1);
    check("t1_pend_tag", 32'(cpl_tag), 32'd1);
    #1 aresetn = 1'b0;
    #1;
    check("t1_mid_cpl_vld",  32'(cpl_vld),  32'd0);
    check("t1_mid_busy",     32'(tag_busy), 32'd0);
    check("t1_mid_idle",     32'(all_idle), 32'd1);
    check("t1_mid_bready",   32'(bready),   32'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    settle();
    check("t1_rel_bready0", 32'(bready), 32'd0);
    cpl_rdy = 1'b1;
    tick();
    check("t1_rel_bready1", 32'(bready), 32'd1);
    repeat (4) tick();
    check("t1_no_cpl",  32'(cpl_vld),  32'd0);
    check("t1_idle",    32'(all_idle), 32'd1);
    cpl_rdy = 1'b0;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
